// File: rtl/bcd_counter_mux_7seg.sv
// N-digit BCD up/down counter with prescaler tick and multiplexed 8-anode 7-segment driver.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_counter_mux_7seg #(
  parameter int CLK_FREQ    = 100000000,
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    rollover,
  output logic [6:0]              seg,
  output logic [7:0]              an
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_MAX   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    roll_q, roll_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [2:0]              idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [7:0]              an_q, an_d;

  logic       tick;
  logic       carry;
  logic [3:0] digit;
  logic [3:0] new_digit;
  logic [3:0] sel_digit;
  logic       blank;
  logic       upper_zero;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign tick = en && (presc_q == PRESC_MAX);

  // Counter: clr beats tick; the carry/borrow chain ripples across all digits in one cycle.
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    roll_d    = 1'b0;
    carry     = 1'b1;
    digit     = '0;
    new_digit = '0;
    if (clr) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick) begin
      presc_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit     = count_q[4*i +: 4];
        new_digit = digit;
        if (carry) begin
          if (up_dn) begin
            if (digit == 4'd9) new_digit = 4'd0;
            else begin
              new_digit = digit + 4'd1;
              carry     = 1'b0;
            end
          end else begin
            if (digit == 4'd0) new_digit = 4'd9;
            else begin
              new_digit = digit - 4'd1;
              carry     = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = new_digit;
      end
      roll_d = carry;
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Scanning free-runs; the display registers look at next-state index and count.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end

    sel_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == 3'(i)) sel_digit = count_d[4*i +: 4];
    end

    blank      = 1'b0;
    upper_zero = 1'b1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (count_d[4*i +: 4] == 4'd0);
      if ((idx_d == 3'(i)) && upper_zero) blank = 1'b1;
    end
`endif

    seg_d        = blank ? 7'h7F : glyph(sel_digit);
    an_d         = 8'hFF;
    an_d[idx_d]  = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
      roll_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 3'd0;
      seg_q   <= 7'h40;
      an_q    <= 8'hFE;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      roll_q  <= roll_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count    = count_q;
  assign rollover = roll_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_bcd_counter_mux_7seg.sv
// Bench for bcd_counter_mux_7seg: CLK_FREQ=10, REFRESH_DIV=2, NUM_DIGITS=4, directed vectors.
module tb_bcd_counter_mux_7seg;

  localparam int CF = 10;
  localparam int ND = 4;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] count;
  logic        rollover;
  logic [6:0]  seg;
  logic [7:0]  an;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference state
  int m_presc, m_val, m_scan, m_idx;
  bit m_roll;
  logic [15:0] exp_q[$];

  bcd_counter_mux_7seg #(
    .CLK_FREQ   (CF),
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .count   (count),
    .rollover(rollover),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'h40; 1: glyph = 7'h79; 2: glyph = 7'h24; 3: glyph = 7'h30;
      4: glyph = 7'h19; 5: glyph = 7'h12; 6: glyph = 7'h02; 7: glyph = 7'h78;
      8: glyph = 7'h00; 9: glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int val, input int idx);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (idx != 0 && val < pow10(idx)) return 7'h7F;
`endif
    return glyph((val / pow10(idx)) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_val = 0; m_scan = 0; m_idx = 0; m_roll = 0;
    exp_q.delete();
  endtask

  // One rising edge: advance the model with current inputs, then compare everything.
  task automatic cycle(input string tag);
    logic [7:0] an_e;
    m_roll = 0;
    if (clr) begin
      m_presc = 0;
      m_val   = 0;
    end else if (en) begin
      if (m_presc == CF - 1) begin
        m_presc = 0;
        if (up_dn) begin
          if (m_val == 9999) begin m_val = 0; m_roll = 1; end
          else m_val++;
        end else begin
          if (m_val == 0) begin m_val = 9999; m_roll = 1; end
          else m_val--;
        end
      end else begin
        m_presc++;
      end
    end
    if (m_scan == RD - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % ND;
    end else begin
      m_scan++;
    end
    exp_q.push_back(to_bcd(m_val));
    an_e = 8'hFF;
    an_e[m_idx] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".count"}, 32'(count), 32'(exp_q.pop_front()));
    check({tag, ".roll"}, 32'(rollover), 32'(m_roll));
    check({tag, ".an"}, 32'(an), 32'(an_e));
    check({tag, ".seg"}, 32'(seg), 32'(model_seg(m_val, m_idx)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".an"}, 32'(an), 32'h00FE);
    check({tag, ".seg"}, 32'(seg), 32'h0040);
    check({tag, ".count"}, 32'(count), 32'h0000);
    check({tag, ".roll"}, 32'(rollover), 32'h0);
  endtask

  initial begin
    logic [6:0] seg_hand;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    reset_n = 1'b1;
    check_reset_state("rst_rel");

    // Count up 120 cycles: 12 ticks, first on the 10th edge
    en = 1'b1;
    up_dn = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      cycle("up");
      if (k == 9)  check("first_tick_pre", 32'(count), 32'h0000);
      if (k == 10) check("first_tick", 32'(count), 32'h0001);
    end
    check("up120", 32'(count), 32'h0012);

    // Count down to 0, then one more tick wraps to 9999
    up_dn = 1'b0;
    repeat (120) cycle("dn");
    check("dn_zero", 32'(count), 32'h0000);
    for (int k = 1; k <= 10; k++) cycle("dn_wrap");
    check("dn_wrap_val", 32'(count), 32'h9999);
    check("dn_wrap_roll", 32'(rollover), 32'h1);
    cycle("dn_after");
    check("dn_roll_clear", 32'(rollover), 32'h0);

    // Direction change mid-period takes effect on the next tick
    up_dn = 1'b1;
    repeat (9) cycle("up_wrap");
    check("up_wrap_val", 32'(count), 32'h0000);
    check("up_wrap_roll", 32'(rollover), 32'h1);
    cycle("up_after");
    check("up_roll_clear", 32'(rollover), 32'h0);

    // Freeze: prescaler is at 1 here, so 9 more enabled edges reach the tick
    en = 1'b0;
    repeat (50) cycle("frz");
    check("freeze", 32'(count), 32'h0000);
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle("unfrz");
      if (k == 8) check("unfrz_pre", 32'(count), 32'h0000);
    end
    check("unfrz_tick", 32'(count), 32'h0001);

    // Climb to 0042 and look at the display per anode
    repeat (41 * CF) cycle("to42");
    check("at42", 32'(count), 32'h0042);
    for (int k = 0; k < 8; k++) begin
      cycle("disp42");
      case (an)
        8'hFE:   seg_hand = 7'h24;
        8'hFD:   seg_hand = 7'h19;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        default: seg_hand = 7'h7F;
`else
        default: seg_hand = 7'h40;
`endif
      endcase
      check("disp42_hand", 32'(seg), 32'(seg_hand));
    end
    repeat (2) cycle("to43");
    check("at43", 32'(count), 32'h0043);

    // Climb to 0457, then clear on the tick cycle
    repeat (414 * CF) cycle("to457");
    check("at457", 32'(count), 32'h0457);
    repeat (CF - 1) cycle("pre_clr");
    clr = 1'b1;
    cycle("clr");
    check("clr_val", 32'(count), 32'h0000);
    check("clr_roll", 32'(rollover), 32'h0);
    clr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle("post_clr");
      if (k == 9) check("post_clr_pre", 32'(count), 32'h0000);
    end
    check("post_clr_tick", 32'(count), 32'h0001);

    // Asynchronous reset mid-period; counting restarts a full period
    repeat (5) cycle("pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle("restart");
      if (k == 9) check("restart_pre", 32'(count), 32'h0000);
    end
    check("restart_tick", 32'(count), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
